// File: rtl/chdr_burst_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : chdr_burst_arbiter_pkg
// Brief    : Shared CHDR tuser field offsets and settings-bus widths.
// Revision : 1.0
//------------------------------------------------------------------------------
package chdr_burst_arbiter_pkg;

   localparam int c_CHDR_TUSER_W = 128;
   localparam int c_CHDR_EOB_BIT = 124;
   localparam int c_SR_ADDR_W    = 8;
   localparam int c_SR_DATA_W    = 32;
   localparam int c_PKT_SIZE_W   = 16;

   function automatic logic is_burst_end(input logic tvalid,
                                         input logic tready,
                                         input logic tlast,
                                         input logic eob);
      return tvalid & tready & tlast & eob;
   endfunction

endpackage
`default_nettype wire

// File: rtl/chdr_burst_arbiter_setting_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : chdr_burst_arbiter_setting_reg
// Brief    : Settings-bus register; captures the low WIDTH bits on an address hit.
// Revision : 1.0
//------------------------------------------------------------------------------
module chdr_burst_arbiter_setting_reg
   import chdr_burst_arbiter_pkg::*;
#(
   parameter logic [c_SR_ADDR_W-1:0] ADDR     = '0,
   parameter int                     WIDTH    = c_PKT_SIZE_W,
   parameter logic [WIDTH-1:0]       AT_RESET = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   set_stb,
   input  logic [c_SR_ADDR_W-1:0] set_addr,
   input  logic [c_SR_DATA_W-1:0] set_data,
   output logic [WIDTH-1:0]       value
);

   logic [WIDTH-1:0] r_value;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_value <= AT_RESET;
      end else if (set_stb && (set_addr == ADDR)) begin
         r_value <= set_data[WIDTH-1:0];
      end
   end

   assign value = r_value;

   // Upper settings bits are intentionally ignored for narrow registers.
   generate
      if (WIDTH < c_SR_DATA_W) begin : g_unused_bits
         logic w_unused;
         assign w_unused = ^set_data[c_SR_DATA_W-1:WIDTH];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/chdr_burst_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : chdr_burst_arbiter
// Brief    : Burst-granular round-robin mux of two CHDR AXI-stream sources into
//            one packet_resizer; grant held until a tlast beat carrying EOB.
// Revision : 1.0
//------------------------------------------------------------------------------
module chdr_burst_arbiter
   import chdr_burst_arbiter_pkg::*;
#(
   parameter logic [c_SR_ADDR_W-1:0] SR_PKT_SIZE0 = 8'd0,
   parameter logic [c_SR_ADDR_W-1:0] SR_PKT_SIZE1 = 8'd1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      set_stb,
   input  logic [c_SR_ADDR_W-1:0]    set_addr,
   input  logic [c_SR_DATA_W-1:0]    set_data,
   input  logic [31:0]               i0_tdata,
   input  logic [c_CHDR_TUSER_W-1:0] i0_tuser,
   input  logic                      i0_tlast,
   input  logic                      i0_tvalid,
   output logic                      i0_tready,
   input  logic [31:0]               i1_tdata,
   input  logic [c_CHDR_TUSER_W-1:0] i1_tuser,
   input  logic                      i1_tlast,
   input  logic                      i1_tvalid,
   output logic                      i1_tready,
   output logic [31:0]               o_tdata,
   output logic [c_CHDR_TUSER_W-1:0] o_tuser,
   output logic                      o_tlast,
   output logic                      o_tvalid,
   input  logic                      o_tready,
   output logic [c_PKT_SIZE_W-1:0]   o_pkt_size,
   output logic [1:0]                grant
);

   // Encodings double as the one-hot grant vector.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } state_t;

   state_t                  r_state;
   logic                    r_rr;
   logic [c_PKT_SIZE_W-1:0] r_pkt_size;
   logic [c_PKT_SIZE_W-1:0] w_size0;
   logic [c_PKT_SIZE_W-1:0] w_size1;
   logic                    w_gnt0;
   logic                    w_gnt1;
   logic                    w_burst_end;

   chdr_burst_arbiter_setting_reg #(
      .ADDR  (SR_PKT_SIZE0),
      .WIDTH (c_PKT_SIZE_W)
   ) u_size0 (
      .clk      (clk),
      .reset    (reset),
      .set_stb  (set_stb),
      .set_addr (set_addr),
      .set_data (set_data),
      .value    (w_size0)
   );

   chdr_burst_arbiter_setting_reg #(
      .ADDR  (SR_PKT_SIZE1),
      .WIDTH (c_PKT_SIZE_W)
   ) u_size1 (
      .clk      (clk),
      .reset    (reset),
      .set_stb  (set_stb),
      .set_addr (set_addr),
      .set_data (set_data),
      .value    (w_size1)
   );

   assign w_gnt0 = (r_state == GNT0);
   assign w_gnt1 = (r_state == GNT1);

   assign o_tdata   = w_gnt1 ? i1_tdata : i0_tdata;
   assign o_tuser   = w_gnt1 ? i1_tuser : i0_tuser;
   assign o_tlast   = w_gnt1 ? i1_tlast : i0_tlast;
   assign o_tvalid  = (w_gnt0 & i0_tvalid) | (w_gnt1 & i1_tvalid);
   assign i0_tready = w_gnt0 & o_tready;
   assign i1_tready = w_gnt1 & o_tready;

   assign w_burst_end = is_burst_end(o_tvalid, o_tready, o_tlast, o_tuser[c_CHDR_EOB_BIT]);

   assign grant      = r_state;
   assign o_pkt_size = r_pkt_size;

   // r_rr = 0 favours port 0 when both request from IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rr       <= 1'b0;
         r_pkt_size <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i0_tvalid && (!i1_tvalid || !r_rr)) begin
                  r_state    <= GNT0;
                  r_pkt_size <= w_size0;
               end else if (i1_tvalid) begin
                  r_state    <= GNT1;
                  r_pkt_size <= w_size1;
               end
            end
            GNT0: begin
               if (w_burst_end) begin
                  r_rr <= 1'b1;
                  if (i1_tvalid) begin
                     r_state    <= GNT1;
                     r_pkt_size <= w_size1;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            GNT1: begin
               if (w_burst_end) begin
                  r_rr <= 1'b0;
                  if (i0_tvalid) begin
                     r_state    <= GNT0;
                     r_pkt_size <= w_size0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
